// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues icache reads and fills the IF/ID latch.
// A redirect that arrives while the PC is stalled is parked and applied once the stall clears.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        memStall,
  input  logic        stallPC,
  input  logic        ifidFreeze,
  input  logic        ifidFlush,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid,
  output logic        halted
);

  logic [31:0] pc_r, pc_nxt_s, pc_plus4_s;
  logic        pend_valid_r, pend_valid_nxt_s;
  logic [31:0] pend_pc_r, pend_pc_nxt_s;
  logic        halted_r, halted_nxt_s;
  logic [31:0] ifid_instr_r, ifid_instr_nxt_s;
  logic [31:0] ifid_npc_r, ifid_npc_nxt_s;
  logic        ifid_valid_r, ifid_valid_nxt_s;
  logic        go_s, take_s, is_halt_s;
  logic [31:0] target_s;

  // Shared control terms; a live redirect beats a parked one.
  always_comb begin
    go_s       = !stallPC && !memStall;
    take_s     = (redirect || pend_valid_r) && go_s;
    target_s   = redirect ? redirectPC : pend_pc_r;
    pc_plus4_s = pc_r + 32'd4;
    is_halt_s  = (iload[31:26] == HALT_OP);
  end

  // Next PC, pending-redirect and halt state.
  always_comb begin
    pc_nxt_s         = pc_r;
    pend_valid_nxt_s = pend_valid_r;
    pend_pc_nxt_s    = pend_pc_r;
    halted_nxt_s     = halted_r;
    if (take_s) begin
      pc_nxt_s         = target_s;
      pend_valid_nxt_s = 1'b0;
      halted_nxt_s     = 1'b0;
    end else if (redirect && !go_s) begin
      pend_valid_nxt_s = 1'b1;
      pend_pc_nxt_s    = redirectPC;
    end else if (halted_r) begin
      pc_nxt_s = pc_r;
    end else if (ihit && go_s) begin
      if (is_halt_s) begin
        halted_nxt_s = 1'b1;
      end else begin
        pc_nxt_s = pc_plus4_s;
      end
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // Next IF/ID contents; a bubble leaves npc untouched since it is meaningless without valid.
  always_comb begin
    ifid_instr_nxt_s = ifid_instr_r;
    ifid_npc_nxt_s   = ifid_npc_r;
    ifid_valid_nxt_s = ifid_valid_r;
    if (ifidFlush) begin
      ifid_instr_nxt_s = 32'd0;
      ifid_npc_nxt_s   = 32'd0;
      ifid_valid_nxt_s = 1'b0;
    end else if (ifidFreeze || memStall) begin
      ifid_valid_nxt_s = ifid_valid_r;
    end else if (take_s || halted_r) begin
      ifid_instr_nxt_s = 32'd0;
      ifid_valid_nxt_s = 1'b0;
    end else if (ihit) begin
      ifid_instr_nxt_s = iload;
      ifid_npc_nxt_s   = pc_plus4_s;
      ifid_valid_nxt_s = 1'b1;
    end else begin
      ifid_instr_nxt_s = 32'd0;
      ifid_valid_nxt_s = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_r         <= PC_INIT;
      pend_valid_r <= 1'b0;
      pend_pc_r    <= 32'd0;
      halted_r     <= 1'b0;
      ifid_instr_r <= 32'd0;
      ifid_npc_r   <= 32'd0;
      ifid_valid_r <= 1'b0;
    end else begin
      pc_r         <= pc_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
      pend_pc_r    <= pend_pc_nxt_s;
      halted_r     <= halted_nxt_s;
      ifid_instr_r <= ifid_instr_nxt_s;
      ifid_npc_r   <= ifid_npc_nxt_s;
      ifid_valid_r <= ifid_valid_nxt_s;
    end
  end

  assign imemREN    = !RST && !halted_r;
  assign imemaddr   = pc_r;
  assign ifid_instr = ifid_instr_r;
  assign ifid_npc   = ifid_npc_r;
  assign ifid_valid = ifid_valid_r;
  assign halted     = halted_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural model pushes expected outputs to a
// scoreboard queue as stimulus is driven; they are popped and compared after each edge.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST, ihit, memStall, stallPC, ifidFreeze, ifidFlush, redirect;
  logic [31:0] iload, redirectPC;
  logic        imemREN, ifid_valid, halted;
  logic [31:0] imemaddr, ifid_instr, ifid_npc;

  fetch_stage dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .memStall(memStall),
    .stallPC(stallPC), .ifidFreeze(ifidFreeze), .ifidFlush(ifidFlush),
    .redirect(redirect), .redirectPC(redirectPC), .imemREN(imemREN),
    .imemaddr(imemaddr), .ifid_instr(ifid_instr), .ifid_npc(ifid_npc),
    .ifid_valid(ifid_valid), .halted(halted)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        npc_known;
    logic        valid;
    logic        halted;
    logic        ren;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference state
  logic [31:0] m_pc = 32'd0, m_pend_pc = 32'd0, m_instr = 32'd0, m_npc = 32'd0;
  logic        m_pend_v = 1'b0, m_halt = 1'b0, m_valid = 1'b0, m_npc_known = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input logic r, input logic hit, input logic [31:0] ld, input logic ms,
                      input logic st, input logic fz, input logic fl, input logic rd,
                      input logic [31:0] rpc);
    logic go, take;
    logic [31:0] tgt, old_pc;
    exp_t e;
    RST = r; ihit = hit; iload = ld; memStall = ms; stallPC = st;
    ifidFreeze = fz; ifidFlush = fl; redirect = rd; redirectPC = rpc;
    go = !st && !ms;
    take = (rd || m_pend_v) && go;
    tgt = rd ? rpc : m_pend_pc;
    old_pc = m_pc;
    // IF/ID uses the pre-edge halt state, so evaluate it first
    if (r || fl) begin
      m_instr = 32'd0; m_npc = 32'd0; m_valid = 1'b0; m_npc_known = 1'b1;
    end else if (fz || ms) begin
      // hold
    end else if (take || m_halt) begin
      m_instr = 32'd0; m_valid = 1'b0;
    end else if (hit) begin
      m_instr = ld; m_npc = old_pc + 32'd4; m_valid = 1'b1; m_npc_known = 1'b1;
    end else begin
      m_instr = 32'd0; m_valid = 1'b0;
    end
    if (r) begin
      m_pc = 32'd0; m_pend_v = 1'b0; m_halt = 1'b0;
    end else if (take) begin
      m_pc = tgt; m_pend_v = 1'b0; m_halt = 1'b0;
    end else if (rd && !go) begin
      m_pend_v = 1'b1; m_pend_pc = rpc;
    end else if (!m_halt && hit && go) begin
      if (ld[31:26] == 6'b111111) m_halt = 1'b1;
      else m_pc = old_pc + 32'd4;
    end
    e.pc = m_pc; e.instr = m_instr; e.npc = m_npc; e.npc_known = m_npc_known;
    e.valid = m_valid; e.halted = m_halt; e.ren = !r && !m_halt;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    check_eq("imemaddr", imemaddr, e.pc);
    check_eq("ifid_instr", ifid_instr, e.instr);
    check_eq("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.valid});
    check_eq("halted", {31'd0, halted}, {31'd0, e.halted});
    check_eq("imemREN", {31'd0, imemREN}, {31'd0, e.ren});
    if (e.npc_known && (e.valid || e.instr == 32'd0 && e.npc == 32'd0))
      check_eq("ifid_npc", ifid_npc, e.npc);
  endtask

  // Shorthands
  task automatic idle(input logic hit, input logic [31:0] ld);
    step(1'b0, hit, ld, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic jump(input logic hit, input logic st, input logic [31:0] rpc);
    step(1'b0, hit, 32'h2008_0001, 1'b0, st, 1'b0, 1'b0, 1'b1, rpc);
  endtask

  localparam logic [31:0] ADDI = 32'h2008_0001;
  localparam logic [31:0] HALT = 32'hFC00_0000;

  initial begin
    // Reset
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, ADDI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("rst_pc", imemaddr, 32'h0);
    check_eq("rst_ren", {31'd0, imemREN}, 32'd0);

    // Streaming hits
    idle(1'b1, ADDI);
    check_eq("hit1_pc", imemaddr, 32'h4);
    check_eq("hit1_npc", ifid_npc, 32'h4);
    check_eq("hit1_ren", {31'd0, imemREN}, 32'd1);
    idle(1'b1, ADDI);
    check_eq("hit2_pc", imemaddr, 32'h8);
    idle(1'b1, ADDI);
    check_eq("hit3_pc", imemaddr, 32'hC);

    // Misses from PC 4
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(1'b1, ADDI);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0, 32'h0);
      check_eq("miss_pc", imemaddr, 32'h4);
      check_eq("miss_valid", {31'd0, ifid_valid}, 32'd0);
    end
    idle(1'b1, 32'h1234_5678);
    check_eq("afterMiss_instr", ifid_instr, 32'h1234_5678);
    check_eq("afterMiss_pc", imemaddr, 32'h8);

    // Stall + freeze hold everything
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, ADDI, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      check_eq("stall_pc", imemaddr, 32'h8);
      check_eq("stall_instr", ifid_instr, 32'h1234_5678);
    end
    idle(1'b1, ADDI);
    check_eq("resume_pc", imemaddr, 32'hC);

    // Redirect parked behind a stall
    step(1'b0, 1'b1, ADDI, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
    step(1'b0, 1'b1, ADDI, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("pend_pc_hold", imemaddr, 32'hC);
    idle(1'b1, ADDI);
    check_eq("pend_apply_pc", imemaddr, 32'h40);
    check_eq("pend_bubble", {31'd0, ifid_valid}, 32'd0);

    // Later redirect overwrites pending; live redirect beats pending
    jump(1'b0, 1'b1, 32'h100);
    jump(1'b0, 1'b1, 32'h200);
    jump(1'b0, 1'b0, 32'h300);
    check_eq("live_beats_pend", imemaddr, 32'h300);
    idle(1'b0, 32'h0);
    check_eq("pend_cleared", imemaddr, 32'h300);

    // Halt and release by redirect
    jump(1'b0, 1'b0, 32'h40);
    idle(1'b1, HALT);
    check_eq("halt_instr", ifid_instr, HALT);
    check_eq("halt_flag", {31'd0, halted}, 32'd1);
    check_eq("halt_ren", {31'd0, imemREN}, 32'd0);
    check_eq("halt_pc", imemaddr, 32'h40);
    idle(1'b1, ADDI);
    check_eq("halted_pc", imemaddr, 32'h40);
    jump(1'b0, 1'b0, 32'h80);
    check_eq("unhalt_flag", {31'd0, halted}, 32'd0);
    check_eq("unhalt_pc", imemaddr, 32'h80);

    // memStall and flush
    step(1'b0, 1'b1, ADDI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("memstall_pc", imemaddr, 32'h80);
    idle(1'b1, ADDI);
    step(1'b0, 1'b1, ADDI, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("flush_valid", {31'd0, ifid_valid}, 32'd0);

    // PC wrap, with a simultaneous hit discarded on the redirect
    jump(1'b1, 1'b0, 32'hFFFF_FFFC);
    idle(1'b1, ADDI);
    check_eq("wrap_npc", ifid_npc, 32'h0);
    check_eq("wrap_pc", imemaddr, 32'h0);

    // Reset mid-miss with a pending redirect
    jump(1'b0, 1'b1, 32'h500);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(1'b0, 32'h0);
    check_eq("rst_drop_pend", imemaddr, 32'h0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ld;
      ld = $urandom;
      if ($urandom_range(0, 9) != 0) ld[31:26] = 6'(ld[31:26] & 6'b011111);
      step(($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 3) != 0), ld,
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 8) == 0),
           1'($urandom_range(0, 6) == 0), {$urandom_range(0, 255), 2'b00});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage for the pipelined core. It owns the PC register, issues instruction reads to the icache, and writes the IF/ID pipeline latch. It applies the stall, freeze and flush controls from the hazard unit, so the instruction it latches is the one the hazard unit checks next cycle. It also holds back a branch/jump redirect that arrives while the PC is stalled, so a redirect is never lost behind a data-hazard stall.

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, reset PC value.
- HALT_OP, 6'b111111, opcode field (instr[31:26]) that stops fetch.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- ihit  in  1  icache returned iload for imemaddr this cycle.
- iload  in  32  instruction word from icache.
- memStall  in  1  dcache busy; whole front end holds.
- stallPC  in  1  hazard unit: hold PC.
- ifidFreeze  in  1  hazard unit: hold IF/ID contents.
- ifidFlush  in  1  hazard unit: clear IF/ID.
- redirect  in  1  taken branch/jump resolved downstream.
- redirectPC  in  32  redirect target.
- imemREN  out  1  instruction read enable.
- imemaddr  out  32  current PC.
- ifid_instr  out  32  latched instruction.
- ifid_npc  out  32  latched PC+4.
- ifid_valid  out  1  latched entry is a real instruction.
- halted  out  1  fetch stopped on HALT_OP.

## Operation
- State: PC (32), pend_valid (1), pend_pc (32), halted (1), IF/ID latch (instr, npc, valid).
- imemaddr = PC. imemREN = !RST && !halted.
- go = !stallPC && !memStall.
- take = (redirect || pend_valid) && go. target = redirect ? redirectPC : pend_pc. A live redirect beats a pending one.

PC and pending update, first match wins:
- RST: PC<=PC_INIT, pend_valid<=0, halted<=0.
- take: PC<=target, pend_valid<=0, halted<=0. Redirect does not wait for ihit; any outstanding miss is abandoned.
- redirect && !go: pend_valid<=1, pend_pc<=redirectPC. A later redirect overwrites the pending one. PC holds.
- halted: hold.
- ihit && go: PC<=PC+4 (mod 2^32). If iload[31:26]==HALT_OP, PC holds instead and halted<=1.
- else: hold.

IF/ID update, first match wins:
- RST or ifidFlush: instr<=0, npc<=0, valid<=0.
- ifidFreeze or memStall: hold.
- take, or halted: bubble (valid<=0, instr<=0). The halt instruction itself is latched before halted is set.
- ihit: instr<=iload, npc<=PC+4, valid<=1.
- else: bubble.

Halt behaviour:
- halted clears only on RST or take. A halt fetched on a wrong path is cancelled by the redirect that follows it.

## Timing
- Reset values: PC=PC_INIT, imemaddr=PC_INIT, imemREN=0 while RST=1 and 1 from the first cycle after. ifid_*=0, ifid_valid=0, halted=0.
- Fetch latency: the instruction at PC is on the ifid_* outputs the cycle after the edge where ihit=1. With continuous hits and no hazards, throughput is one instruction per cycle.
- Redirect with go=1: imemaddr=redirectPC the next cycle. IF/ID holds a bubble unless ifidFlush/ifidFreeze take priority.
- Redirect with stallPC=1: captured into pend_pc. It is applied on the first cycle with go=1, one cycle after stallPC drops, and needs no second redirect pulse.
- Simultaneous ihit and take: the fetched word is discarded and the PC goes to target.
- PC wrap: 32'hFFFF_FFFC + 4 = 0, and ifid_npc=0.
- RST mid-miss or mid-pending: everything returns to reset values on that edge; pending is dropped.

## Test plan
- Reset, then iload=32'h2008_0001 and ihit=1 for 3 cycles: imemaddr 0→4→8→C, ifid_valid=1, ifid_npc=4 after the first hit.
- ihit=0 for 4 cycles: PC holds at 4 and ifid_valid=0 each cycle. On a hit, ifid_instr=iload and PC=8.
- stallPC=1 and ifidFreeze=1 for 2 cycles with ihit=1: PC and IF/ID unchanged. Normal flow resumes the cycle after the stall drops.
- redirect=1 with redirectPC=32'h40 while stallPC=1, then stallPC=0 two cycles later: pend_valid set, PC=0x40 one cycle after the release, no instruction latched from the old path.
- ihit with iload=32'hFC00_0000: ifid_instr=32'hFC00_0000, then halted=1, imemREN=0, PC frozen. A redirect to 0x80 clears halted and sets imemaddr=0x80.
- PC preset near top via redirect to 32'hFFFF_FFFC, then ihit: ifid_npc=0 and PC=0. Assert RST mid-miss with pend_valid=1: all outputs return to reset values next cycle.
